// File: rtl/reg_file_float_mp.sv
// FP register file with NUM_RD comb read ports, NUM_WR write ports, busy scoreboard and optional write->read bypass.
// Latency: reads 0 cycles, writes/busy updates commit at posedge; backpressure: none, every port accepted every cycle.
module reg_file_float_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_vec
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     wr_dat [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] alloc_hit;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Per-register write decode; ascending port scan lets the highest port win.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_dat[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_dat[r] = wr_data[j*XLEN +: XLEN];
        end
      end
      alloc_hit[r] = alloc_en && (alloc_addr == AW'(r));
      if (HAS_ZERO && (r == 0)) begin
        wr_hit[r]    = 1'b0;
        alloc_hit[r] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (alloc_hit[r]) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_dat[r];
        end
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = rst ? '0 : busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            is_zero;
    logic            byp_hit;
    logic [XLEN-1:0] byp_dat;
    logic [XLEN-1:0] dat;
    logic            bsy;

    assign ra      = rd_addr[i*AW +: AW];
    assign is_zero = HAS_ZERO && (ra == '0);

    always_comb begin
      byp_hit = 1'b0;
      byp_dat = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
          byp_hit = 1'b1;
          byp_dat = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    // A forwarded write clears busy unless a newer producer is allocated this cycle.
    always_comb begin
      dat = regs_q[ra];
      bsy = busy_q[ra];
      if (HAS_BYP && byp_hit) begin
        dat = byp_dat;
        bsy = alloc_en && (alloc_addr == ra);
      end
      if (rst || is_zero) begin
        dat = '0;
        bsy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = dat;
    assign rd_busy[i]              = bsy;
  end

endmodule
